iterative_normalizer: RTL and testbench
=======================================

// Module: iterative_normalizer
// PURPOSE
//  Inverse of the ALU barrel shifter: given a data word, finds the left-shift amount that
//  brings its most significant 1 to bit BITS-1, and returns the normalized word.
//  Iterative binary search: one stage per cycle, widest stage (BITS/2) first.
//  Provides CLZ / normalize for the ALU and FP-prep datapath.
//  Uses valid/ready handshakes on both input and output.
// PARAMETERS
//  BITS  32  data width; power of two, >= 2; L = $clog2(BITS) search stages
// PORTS
//  clk        in   1      single clock; all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      a is valid
//  in_ready   out  1      block accepts a; high only in IDLE
//  a          in   BITS   word to normalize
//  out_valid  out  1      result valid; held until accepted
//  out_ready  in   1      consumer accepts the result
//  out        out  BITS   a << shamt (normalized word)
//  shamt      out  L      leading-zero count of a (0 when zero=1)
//  zero       out  1      a was all zeros
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE, out_valid=0, out=0, shamt=0, zero=0.
//  FSM states:
//   - IDLE:  in_ready=1. Accept on in_valid&in_ready.
//            a!=0: load work reg <= a, shamt <= 0, k <= L-1, zero <= 0; go to SHIFT.
//            a==0: out <= 0, shamt <= 0, zero <= 1; go to DONE.
//   - SHIFT: one stage per cycle, stage k tests the top 2^k bits of the work reg.
//            If they are all 0: reg <= reg << 2^k (zero-filled) and shamt[k] <= 1.
//            Otherwise reg and shamt[k] are unchanged.
//            When k==0, go to DONE after this stage; else k <= k-1.
//   - DONE:  out_valid=1; out, shamt and zero are held stable.
//            On out_valid&out_ready, go to IDLE.
//  Latency, counted from the accept edge:
//   - nonzero a: out_valid high after L+1 edges (6 for BITS=32).
//   - a==0: out_valid high after 1 edge.
//  Throughput: no overlap. in_ready=0 in SHIFT and DONE, and in_valid there is ignored.
//   Back-to-back best case is one word per L+2 cycles.
//  Invariants while out_valid=1:
//   - zero=0 implies out[BITS-1]=1 and out == (a << shamt) truncated to BITS.
//   - zero=1 implies out=0 and shamt=0.
//  Outputs out, shamt and zero are registered; no combinational path from a to any output.
//  Backpressure: out_ready low holds DONE indefinitely with outputs frozen.
//  Reset mid-operation (SHIFT or DONE): result discarded; no out_valid pulse after release.
//  Boundaries:
//   - a=1 gives shamt=BITS-1.
//   - a with MSB set gives shamt=0 and out=a.
// TESTING
//  1 a=32'h0000_0001 accepted -> after 6 edges out_valid=1, out=32'h8000_0000, shamt=31, zero=0.
//  2 a=32'h8000_0001 -> shamt=0, out=32'h8000_0001, zero=0.
//  3 a=32'h00F0_0000 -> shamt=8, out=32'hF000_0000. Check shamt bits set only at stage k=3.
//  4 a=0 -> after 1 edge out_valid=1, zero=1, out=0, shamt=0.
//  5 out_ready=0 for 10 cycles in DONE with in_valid pulsed -> outputs stable, in_ready=0,
//    pulses ignored. Then out_ready=1 -> IDLE next edge, in_ready=1.
//  6 rst_n low 2 cycles after accepting 32'h0001_0000 -> outputs reset at once, no out_valid.
//    After release, a=32'h0001_0000 -> shamt=15, out=32'h8000_0000.

Source files
------------

// File: rtl/iterative_normalizer.sv
// Iterative normalizer / count-leading-zeros unit.
// A binary search over the leading-zero count runs one stage per cycle,
// starting at the widest stage (BITS/2) and ending at the 1-bit stage.
// The result comes out with the most significant 1 at bit BITS-1, together
// with the shift amount that got it there.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE. out_valid is high only in DONE
// and stays high, with out/shamt/zero frozen, until out_ready is seen.
module iterative_normalizer #(
    parameter int  BITS = 32,
    localparam int L    = $clog2(BITS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] a,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out,
    output logic [L-1:0]    shamt,
    output logic            zero
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [L-1:0] K_TOP = L'(L - 1);

    state_t          state_q, state_d;
    logic [BITS-1:0] work_q, work_d;
    logic [L-1:0]    shamt_q, shamt_d;
    logic [L-1:0]    k_q, k_d;
    logic            zero_q, zero_d;

    // Stage k looks at the top 2^k bits of the work register.
    int unsigned     stage_w;
    logic [BITS-1:0] top_bits;
    logic [BITS-1:0] shifted;

    // State and datapath registers; reset clears every visible output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            shamt_q <= '0;
            k_q     <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            shamt_q <= shamt_d;
            k_q     <= k_d;
            zero_q  <= zero_d;
        end
    end

    // Next-state logic: accept in IDLE, one search stage per cycle in SHIFT,
    // hold the result in DONE until the consumer takes it.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        shamt_d  = shamt_q;
        k_d      = k_q;
        zero_d   = zero_q;
        stage_w  = 32'd1 << k_q;
        top_bits = work_q >> (BITS - stage_w);
        shifted  = work_q << stage_w;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shamt_d = '0;
                    if (a != '0) begin
                        work_d  = a;
                        k_d     = K_TOP;
                        zero_d  = 1'b0;
                        state_d = ST_SHIFT;
                    end else begin
                        // All-zero input skips the search entirely.
                        work_d  = '0;
                        zero_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                if (top_bits == '0) begin
                    work_d       = shifted;
                    shamt_d[k_q] = 1'b1;
                end
                if (k_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out       = work_q;
    assign shamt     = shamt_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_iterative_normalizer.sv
// Bench for iterative_normalizer (BITS=32): directed vector table, hand
// sequences for the multi-cycle corners, then random words checked against
// a leading-zero-count reference model.
module tb_iterative_normalizer;

    localparam int BITS = 32;
    localparam int L    = 5;
    localparam int LAT  = L + 1;
    localparam int MAXW = 50;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] a;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] out;
    logic [L-1:0]    shamt;
    logic            zero;

    int n_tests;
    int n_fail;

    iterative_normalizer #(.BITS(BITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .shamt     (shamt),
        .zero      (zero)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [BITS-1:0] a;
        logic [BITS-1:0] exp_out;
        logic [L-1:0]    exp_shamt;
        logic            exp_zero;
        int              exp_lat;
    } vec_t;

    vec_t tbl[6];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference: count zeros from the MSB down; normalized word is a << count.
    function automatic void ref_model(input logic [BITS-1:0] v, output logic [BITS-1:0] o,
                                      output logic [L-1:0] s, output logic z);
        int n;
        n = 0;
        z = (v == '0);
        if (z) begin
            o = '0;
            s = '0;
        end else begin
            while (v[BITS-1-n] == 1'b0) n++;
            o = v << n;
            s = L'(n);
        end
    endfunction

    // Drive one word, measure latency, hold in DONE for 'hold' cycles, check, drain.
    task automatic run_txn(input string tag, input logic [BITS-1:0] v, input logic [BITS-1:0] e_out,
                           input logic [L-1:0] e_sh, input logic e_z, input int e_lat, input int hold);
        int lat;
        @(negedge clk);
        chk({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        a        = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        lat = 1;
        while (!out_valid && lat < MAXW) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(e_lat));
        repeat (hold) @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".out"},       64'(out),       64'(e_out));
        chk({tag, ".shamt"},     64'(shamt),     64'(e_sh));
        chk({tag, ".zero"},      64'(zero),      64'(e_z));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".drain_in_ready"},  64'(in_ready),  64'd1);
        chk({tag, ".drain_out_valid"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [BITS-1:0] r_out, v, hold_out;
        logic [L-1:0]    r_sh, hold_sh;
        logic            r_z, hold_z;
        logic [L-1:0]    trace[6];
        int              seen;

        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;

        tbl[0] = '{32'h0000_0001, 32'h8000_0000, 5'd31, 1'b0, LAT};
        tbl[1] = '{32'h8000_0001, 32'h8000_0001, 5'd0,  1'b0, LAT};
        tbl[2] = '{32'h00F0_0000, 32'hF000_0000, 5'd8,  1'b0, LAT};
        tbl[3] = '{32'h0000_0000, 32'h0000_0000, 5'd0,  1'b1, 1};
        tbl[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  1'b0, LAT};
        tbl[5] = '{32'h0000_0003, 32'hC000_0000, 5'd30, 1'b0, LAT};

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.in_ready",  64'(in_ready),  64'd1);
        chk("rst.out",       64'(out),       64'd0);
        chk("rst.shamt",     64'(shamt),     64'd0);
        chk("rst.zero",      64'(zero),      64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 6; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i].a, tbl[i].exp_out, tbl[i].exp_shamt,
                    tbl[i].exp_zero, tbl[i].exp_lat, 0);
        end

        // Stage trace for 00F0_0000: only the k=3 stage sets a shamt bit.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'h00F0_0000;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            trace[e] = shamt;
        end
        chk("trace.after_accept", 64'(trace[0]), 64'd0);
        chk("trace.after_k4",     64'(trace[1]), 64'd0);
        chk("trace.after_k3",     64'(trace[2]), 64'd8);
        chk("trace.after_k2",     64'(trace[3]), 64'd8);
        chk("trace.after_k0",     64'(trace[5]), 64'd8);
        chk("trace.out",          64'(out),      64'hF000_0000);
        chk("trace.done",         64'(out_valid), 64'd1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Backpressure: hold DONE for 10 cycles while in_valid is pulsed.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'h0000_0400;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < MAXW) begin
            @(posedge clk);
            #1;
            seen++;
        end
        hold_out = out;
        hold_sh  = shamt;
        hold_z   = zero;
        chk("bp.captured_out",   64'(hold_out), 64'h8000_0000);
        chk("bp.captured_shamt", 64'(hold_sh),  64'd21);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = c[0];
            a        = 32'h0000_0001 << c;
            @(posedge clk);
            #1;
            chk($sformatf("bp.c%0d.out", c),       64'(out),       64'(hold_out));
            chk($sformatf("bp.c%0d.shamt", c),     64'(shamt),     64'(hold_sh));
            chk($sformatf("bp.c%0d.zero", c),      64'(zero),      64'(hold_z));
            chk($sformatf("bp.c%0d.in_ready", c),  64'(in_ready),  64'd0);
            chk($sformatf("bp.c%0d.out_valid", c), 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp.release.in_ready",  64'(in_ready),  64'd1);
        chk("bp.release.out_valid", 64'(out_valid), 64'd0);

        // Reset mid-operation: discard result, no out_valid afterwards.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'h0001_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst.out",       64'(out),       64'd0);
        chk("midrst.shamt",     64'(shamt),     64'd0);
        chk("midrst.zero",      64'(zero),      64'd0);
        chk("midrst.out_valid", 64'(out_valid), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("midrst.no_valid_pulse", 64'(seen), 64'd0);
        run_txn("midrst.retry", 32'h0001_0000, 32'h8000_0000, 5'd15, 1'b0, LAT, 0);

        // Random words against the reference model
        for (int i = 0; i < 150; i++) begin
            v = $urandom;
            v = v >> $urandom_range(0, 32);
            ref_model(v, r_out, r_sh, r_z);
            run_txn($sformatf("rnd%0d(%08h)", i, v), v, r_out, r_sh, r_z,
                    r_z ? 1 : LAT, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
